// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle; master = controller, slave = datapath
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        adr_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_control;
  logic [1:0]  result_src;
  logic        len_sel;
  logic [3:0]  state;
  modport master (
    input  instr, alu_flags,
    output pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
           alu_src_b, alu_control, result_src, len_sel, state
  );
  modport slave (
    output instr, alu_flags,
    input  pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
           alu_src_b, alu_control, result_src, len_sel, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle processor control FSM with NZCV flags and condition evaluation
// COND_EXEC_EN enables ARM conditional execution; without it every instruction executes.
module multicycle_ctrl (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctrl_if.master bus
);
  localparam logic [3:0] FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3,
                         MEMWB  = 4'd4, MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7,
                         ALUWB  = 4'd8, BRANCH = 4'd9;
  logic [3:0] state_q, state_d, flags_q, flags_d, cond, cmd;
  logic [1:0] op, dp_op;
  logic [5:0] funct;
  logic       cond_ok, is_cmp, pcw, irw, rw, mw, unused_bits;
  assign cond   = bus.instr[31:28];
  assign op     = bus.instr[27:26];
  assign funct  = bus.instr[25:20];
  assign cmd    = funct[4:1];
  assign is_cmp = cmd == 4'b1010;
  assign dp_op  = (cmd == 4'b0010 || is_cmp) ? 2'b01 :
                  cmd == 4'b0000 ? 2'b10 :
                  cmd == 4'b1100 ? 2'b11 : 2'b00;
`ifdef COND_EXEC_EN
  logic n, z, c, v;
  assign {n, z, c, v} = flags_q;
  assign unused_bits = ^{bus.instr[19:16], bus.instr[11:0]};
  always_comb begin
    case (cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = !c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = c && !z;
      4'b1001: cond_ok = !c || z;
      4'b1010: cond_ok = n == v;
      4'b1011: cond_ok = n != v;
      4'b1100: cond_ok = !z && (n == v);
      4'b1101: cond_ok = z || (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  assign cond_ok     = 1'b1;
  assign unused_bits = ^{cond, flags_q, bus.instr[19:16], bus.instr[11:0]};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = op == 2'b01 ? MEMADR :
                        op == 2'b00 ? (funct[5] ? EXECI : EXECR) :
                        op == 2'b10 ? BRANCH : FETCH;
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end
  assign flags_d = ((state_q == EXECR || state_q == EXECI) && (funct[0] || is_cmp) && cond_ok)
                   ? bus.alu_flags : flags_q;
  always_comb begin
    pcw             = 1'b0;
    irw             = 1'b0;
    rw              = 1'b0;
    mw              = 1'b0;
    bus.adr_src     = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = 2'b00;
    bus.result_src  = 2'b00;
    bus.len_sel     = 1'b0;
    case (state_q)
      FETCH: begin
        irw            = 1'b1;
        pcw            = 1'b1;
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      DECODE: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      MEMADR: begin
        bus.alu_src_b = 2'b01;
        bus.len_sel   = 1'b1;
      end
      MEMRD: bus.adr_src = 1'b1;
      MEMWB: begin
        bus.result_src = 2'b01;
        rw             = cond_ok;
      end
      MEMWR: begin
        bus.adr_src = 1'b1;
        mw          = cond_ok;
      end
      EXECR: bus.alu_control = dp_op;
      EXECI: begin
        bus.alu_src_b   = 2'b01;
        bus.alu_control = dp_op;
      end
      ALUWB: begin
        rw  = cond_ok && !is_cmp;
        pcw = cond_ok && bus.instr[15:12] == 4'hF;
      end
      BRANCH: begin
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        bus.len_sel    = 1'b1;
        pcw            = cond_ok;
      end
      default: ;
    endcase
  end
  // Write enables drop the moment reset asserts, independent of the clock.
  assign bus.pc_write  = pcw && rst_n;
  assign bus.ir_write  = irw && rst_n;
  assign bus.reg_write = rw && rst_n;
  assign bus.mem_write = mw && rst_n;
  assign bus.state     = state_q;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Control FSM for the multicycle variant of the processor.
- Sequences fetch, decode, execute, memory and writeback over several clock cycles of one shared ALU/memory datapath.
- Drives all datapath mux selects and write enables, including `len_sel` of the immediate extend unit.
- Holds the NZCV flag register and evaluates condition codes.

## Interface
Parameters:
- none (all encodings fixed below)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr`  in  32  IR contents; uses cond[31:28], op[27:26], funct[25:20], rd[15:12]
- `alu_flags`  in  4  NZCV from ALU, current cycle
- `pc_write`  out  1  PC load enable
- `ir_write`  out  1  IR load enable
- `reg_write`  out  1  register-file write enable
- `mem_write`  out  1  data-memory write enable
- `adr_src`  out  1  memory address: 0=PC, 1=ALUOut
- `alu_src_a`  out  1  0=RD1, 1=PC
- `alu_src_b`  out  2  00=RD2, 01=ExtImm, 10=constant 4
- `alu_control`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `result_src`  out  2  00 ALUOut, 01 read data, 10 ALU result (direct)
- `len_sel`  out  1  to extend unit: 0=8-bit immediate, 1=12-bit immediate
- `state`  out  4  current state code (debug)

## Operation
- States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- State codes 10–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH -> DECODE.
- DECODE selects by op:
  - op=01 -> MEMADR
  - op=00, funct[5]=0 -> EXECR
  - op=00, funct[5]=1 -> EXECI
  - op=10 -> BRANCH
  - op=11 -> FETCH (no-op)
- MEMADR -> MEMRD if funct[0]=1 (load), else -> MEMWR.
- MEMRD -> MEMWB -> FETCH.
- MEMWR -> FETCH.
- EXECR/EXECI -> ALUWB -> FETCH.
- BRANCH -> FETCH.

Outputs are Moore-style, decoded from state plus instr. Unlisted enables are 0; unlisted selects are 0.
- FETCH: adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, ADD, result_src=10, pc_write=1.
- DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10.
- MEMADR: alu_src_b=01, len_sel=1, ADD.
- MEMRD: adr_src=1.
- MEMWB: result_src=01, reg_write=cond_ok.
- MEMWR: adr_src=1, mem_write=cond_ok.
- EXECR: alu_src_b=00, ALU op from cmd=funct[4:1].
  - 0100 -> ADD, 0010 -> SUB, 1010 (CMP) -> SUB, 0000 -> AND, 1100 -> ORR.
  - Any other cmd -> ADD.
- EXECI: same as EXECR but alu_src_b=01, len_sel=0.
- ALUWB: result_src=00.
  - reg_write=cond_ok, except CMP, where reg_write=0.
  - pc_write=cond_ok when rd=15.
- BRANCH: alu_src_b=01, ADD, result_src=10, pc_write=cond_ok.
  - len_sel=1; the branch offset path lies outside the extend unit.

Flags and condition codes:
- Flags register loads `alu_flags` on the rising edge that leaves EXECR/EXECI, only when funct[0]=1 and cond_ok=1. CMP always loads flags when cond_ok=1.
- cond_ok is combinational from cond and the stored flags, using the standard ARM mapping (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL).
- cond=1111 gives cond_ok=0.

## Timing
- Cycles per instruction: branch 3; data-processing 4; STR 4; LDR 5; op=11 2.
- `instr` is captured at the end of FETCH and is valid from DECODE until the next FETCH edge.

Reset:
- While rst_n=0: state=FETCH and flags=0000.
- pc_write, ir_write, reg_write and mem_write are forced to 0 asynchronously; selects hold their FETCH values.
- Reset mid-instruction aborts immediately. No partial write occurs after rst_n falls.
- The first fetch completes on the first rising edge with rst_n=1.
- A failing condition never suppresses state transitions, only writes and flag updates.

## Configuration
- `COND_EXEC_EN` defined: conditional execution as specified above.
- `COND_EXEC_EN` undefined:
  - cond_ok is forced to 1 and cond[31:28] is ignored (1111 also executes).
  - The flag register is still updated per the S bit.

## Test plan
- Reset with rst_n=0 held 3 cycles, then released -> state=0, all enables 0 during reset, first edge after release gives state=1.
- LDR: instr=0xE5912004 -> states 0,1,2,3,4,0 with len_sel=1 in MEMADR and reg_write=1 only in MEMWB.
- ADDS immediate: instr=0xE2910001, alu_flags=0100 -> EXECI has len_sel=0, ADD; flags=0100 after EXECI; ALUWB has reg_write=1.
- BEQ with Z=0 (0x0A000002) -> 3 cycles, pc_write=0 in BRANCH. With Z=1 -> pc_write=1.
- CMP then ORR into r15: CMP gives reg_write=0 in ALUWB; ORR with rd=15 asserts reg_write and pc_write together.
- Assert rst_n low during MEMWR of an STR -> mem_write drops within the same cycle, and state is 0.
